// File: rtl/sd_cmd_ctrl.sv
// SD SPI-mode command sequencer: shifts out the 6-byte command frame through the
// byte engine handshake, then polls with 0xFF until an R1 byte (bit 7 clear) or NCR_MAX polls.
module sd_cmd_ctrl #(
  parameter int NCR_MAX = 8,
  parameter int N       = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [6:0]   cmd_crc,
  output logic         busy,
  output logic         resp_valid,
  output logic         timeout,
  output logic [N-1:0] r1,
  output logic [N-1:0] spi_datain,
  output logic         spi_en,
  input  logic [N-1:0] spi_dataout,
  input  logic         spi_done
);

  // IDLE wait start | LOAD present byte | XFER en high | GAP wait done low | NEXT advance | DONE_* report
  typedef enum logic [2:0] {IDLE, LOAD, XFER, GAP, NEXT, DONE_OK, DONE_TO} state_t;

  localparam logic [7:0] POLL_LIM = 8'(NCR_MAX);

  state_t       state_q, state_d;
  logic [47:0]  frame_q, frame_d;
  logic [2:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]   poll_cnt_q, poll_cnt_d;
  logic         poll_phase_q, poll_phase_d;
  logic [N-1:0] rx_q, rx_d;
  logic [N-1:0] r1_q, r1_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      byte_cnt_q   <= '0;
      poll_cnt_q   <= '0;
      poll_phase_q <= 1'b1;
      rx_q         <= {N{1'b1}};
      r1_q         <= {N{1'b1}};
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      byte_cnt_q   <= byte_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      poll_phase_q <= poll_phase_d;
      rx_q         <= rx_d;
      r1_q         <= r1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    byte_cnt_d   = byte_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    poll_phase_d = poll_phase_q;
    rx_d         = rx_q;
    r1_d         = r1_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d      = {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1};
          byte_cnt_d   = '0;
          poll_cnt_d   = '0;
          poll_phase_d = 1'b0;
          r1_d         = {N{1'b1}};
          state_d      = LOAD;
        end
      end
      LOAD: state_d = XFER;
      XFER: begin
        if (spi_done) begin
          if (poll_phase_q) rx_d = spi_dataout;
          state_d = GAP;
        end
      end
      GAP: begin
        if (!spi_done) state_d = NEXT;
      end
      NEXT: begin
        if (!poll_phase_q) begin
          if (byte_cnt_q < 3'd5) begin
            frame_d    = {frame_q[39:0], 8'h00};
            byte_cnt_d = byte_cnt_q + 3'd1;
          end else begin
            poll_phase_d = 1'b1;
          end
          state_d = LOAD;
        end else if (!rx_q[N-1]) begin
          r1_d    = rx_q;
          state_d = DONE_OK;
        end else begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          if (poll_cnt_q + 8'd1 == POLL_LIM) begin
            r1_d    = {N{1'b1}};
            state_d = DONE_TO;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE_OK: state_d = IDLE;
      DONE_TO: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // During polling (and when idle) the line carries 0xFF; otherwise the frame's top byte.
  assign spi_datain = poll_phase_q ? {N{1'b1}} : frame_q[47:40];
  assign spi_en     = (state_q == XFER);
  assign busy       = (state_q == LOAD) || (state_q == XFER) || (state_q == GAP) || (state_q == NEXT);
  assign resp_valid = (state_q == DONE_OK);
  assign timeout    = (state_q == DONE_TO);
  assign r1         = r1_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Bench for sd_cmd_ctrl: randomised SPI engine stub plus a transaction-level model
// that predicts the MOSI byte list and outcome from the command and the poll responses.
module tb_sd_cmd_ctrl;
  localparam int NCR_MAX = 8;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        busy, resp_valid, timeout, spi_en, spi_done;
  logic [7:0]  r1, spi_datain, spi_dataout;

  sd_cmd_ctrl #(.NCR_MAX(NCR_MAX), .N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc), .busy(busy), .resp_valid(resp_valid), .timeout(timeout), .r1(r1),
    .spi_datain(spi_datain), .spi_en(spi_en), .spi_dataout(spi_dataout), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg,
                                              input logic [6:0] crc);
    return {2'b01, idx, arg, crc, 1'b1};
  endfunction

  // Engine stub configuration and response table (index = poll number)
  logic [7:0] resp_cfg [16];
  int lat_max = 1, hold_min = 1, hold_max = 1;
  int stub_bidx = 0;

  // Model / monitor state
  logic [7:0] exp_q [$];
  bit         exp_ok;
  logic [7:0] exp_r1;
  bit         in_cmd = 0, mdl_idle = 1;
  bit         prev_en = 0;
  logic [7:0] prev_din = 8'hFF;
  int         rises = 0, n_done = 0, last_rises = 0;
  logic [7:0] last_r1 = 8'h00;
  bit         last_was_to = 0;

  task automatic predict(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    logic [47:0] f;
    f = build_frame(idx, arg, crc);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(f[47-8*i -: 8]);
    exp_ok = 0;
    exp_r1 = 8'hFF;
    for (int p = 0; p < NCR_MAX; p++) begin
      exp_q.push_back(8'hFF);
      if (!resp_cfg[p][7]) begin
        exp_ok = 1;
        exp_r1 = resp_cfg[p];
        break;
      end
    end
  endtask

  // SPI engine stub: done rises 1..lat_max cycles after en, stays high hold cycles
  initial begin
    int lat, hold, hold_n;
    bit in_x, rst_s;
    lat = 0; hold = 0; hold_n = 1; in_x = 0;
    spi_done = 1'b0;
    spi_dataout = 8'hFF;
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      if (rst_s) begin
        lat = 0; hold = 0; in_x = 0; stub_bidx = 0;
        spi_done = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) spi_done = 1'b0;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          if (stub_bidx < 6) spi_dataout = 8'($urandom);
          else if (stub_bidx - 6 < 16) spi_dataout = resp_cfg[stub_bidx-6];
          else spi_dataout = 8'hFF;
          stub_bidx++;
          spi_done = 1'b1;
          hold = hold_n;
        end
      end else if (spi_en && !in_x) begin
        in_x = 1;
        lat = $urandom_range(lat_max, 1);
        hold_n = $urandom_range(hold_max, hold_min);
      end else if (!spi_en) begin
        in_x = 0;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      check("busy", busy, in_cmd && !(resp_valid || timeout));
      check("pulse_exclusive", resp_valid & timeout, 1'b0);
      check("en_implies_busy", spi_en & ~busy, 1'b0);
      if (spi_en && prev_en) check("datain_stable", spi_datain, prev_din);
      if (spi_en && !prev_en) begin
        rises++;
        check("en_rise_done_low", spi_done, 1'b0);
        if (in_cmd && exp_q.size() > 0) check("mosi_byte", spi_datain, exp_q.pop_front());
        else check("unexpected_en", spi_en & ~prev_en, 1'b0);
      end
      if (resp_valid || timeout) begin
        check("pulse_in_cmd", in_cmd, 1'b1);
        check("bytes_left", exp_q.size(), 0);
        check("resp_valid", resp_valid, exp_ok);
        check("timeout", timeout, !exp_ok);
        check("r1", r1, exp_ok ? exp_r1 : 8'hFF);
        last_r1 = r1; last_rises = rises; last_was_to = timeout;
        n_done++;
      end
      prev_en = spi_en;
      prev_din = spi_datain;
      if (reset) begin
        in_cmd = 0; mdl_idle = 1; exp_q.delete();
      end else begin
        if (mdl_idle && start === 1'b1) begin
          predict(cmd_index, cmd_arg, cmd_crc);
          in_cmd = 1; mdl_idle = 0; stub_bidx = 0; rises = 0;
        end
        if (resp_valid || timeout) begin
          in_cmd = 0; mdl_idle = 1;
        end
      end
    end
  end

  // Starts in the first IDLE cycle (posedge+1) and returns in the first IDLE cycle after.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input int inject_at, input int reset_at_byte);
    int d0;
    bit got;
    d0 = n_done; got = 0;
    cmd_index = idx; cmd_arg = arg; cmd_crc = crc; start = 1;
    @(posedge clk); #1;
    start = 0;
    cmd_index = 6'($urandom); cmd_arg = $urandom; cmd_crc = 7'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (n_done != d0) begin got = 1; break; end
      #1;
      if (c == inject_at) begin start = 1; cmd_index = idx ^ 6'h15; end
      else start = 0;
      if (reset_at_byte > 0 && rises >= reset_at_byte) begin
        start = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("rst_mid_en", spi_en, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_datain", spi_datain, 8'hFF);
        @(posedge clk); #1;
        return;
      end
    end
    #1;
    start = 0;
    check("cmd_complete", got, 1'b1);
    if (!got) begin
      reset = 1; @(posedge clk); #1; reset = 0;
    end
  endtask

  task automatic set_resp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < 16; i++) resp_cfg[i] = 8'hFF;
    resp_cfg[0] = a; resp_cfg[1] = b; resp_cfg[2] = c;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within bound");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; cmd_index = '0; cmd_arg = '0; cmd_crc = '0;
    set_resp(8'hFF, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_r1", r1, 8'hFF);
    check("rst_spi_en", spi_en, 1'b0);
    check("rst_spi_datain", spi_datain, 8'hFF);
    check("model_frame_cmd0", build_frame(6'd0, 32'h0, 7'h4A), 48'h40_00_00_00_00_95);
    check("model_frame_cmd8", build_frame(6'd8, 32'h1AA, 7'h43), 48'h48_00_00_01_AA_87);
    reset = 0;
    @(posedge clk); #1;

    // CMD0: two busy polls then idle-state R1
    lat_max = 2; hold_min = 1; hold_max = 2;
    set_resp(8'hFF, 8'hFF, 8'h01);
    run_cmd(6'd0, 32'h0, 7'h4A, -1, 0);
    check("cmd0_r1", last_r1, 8'h01);
    check("cmd0_bytes", last_rises, 9);
    check("cmd0_ok", last_was_to, 1'b0);

    // CMD8 back-to-back: R1 on first poll
    set_resp(8'h01, 8'hFF, 8'hFF);
    run_cmd(6'd8, 32'h1AA, 7'h43, -1, 0);
    check("cmd8_r1", last_r1, 8'h01);
    check("cmd8_bytes", last_rises, 7);

    // No response at all
    set_resp(8'hFF, 8'hFF, 8'hFF);
    run_cmd(6'd55, 32'h0, 7'h32, -1, 0);
    check("to_flag", last_was_to, 1'b1);
    check("to_r1", last_r1, 8'hFF);
    check("to_bytes", last_rises, 14);

    // Start pulse with a different index during the transfer
    set_resp(8'hFF, 8'h00, 8'hFF);
    run_cmd(6'd17, 32'h0000_0200, 7'h2A, 10, 0);
    check("ignored_start_bytes", last_rises, 8);
    check("ignored_start_r1", last_r1, 8'h00);

    // Reset while byte B3 is in flight, then a clean CMD0
    run_cmd(6'd16, 32'h0000_0200, 7'h0A, -1, 4);
    set_resp(8'h01, 8'hFF, 8'hFF);
    run_cmd(6'd0, 32'h0, 7'h4A, -1, 0);
    check("post_rst_bytes", last_rises, 7);
    check("post_rst_r1", last_r1, 8'h01);

    // done held 5 extra cycles on every byte
    hold_min = 6; hold_max = 6;
    set_resp(8'hFF, 8'h05, 8'hFF);
    run_cmd(6'd17, 32'h1234_5678, 7'h11, -1, 0);
    check("hold_r1", last_r1, 8'h05);
    check("hold_bytes", last_rises, 8);

    // Randomised commands, responses and engine timing
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(9, 0) < 8) resp_cfg[i] = 8'h80 | 8'($urandom);
        else resp_cfg[i] = 8'($urandom) & 8'h7F;
      end
      lat_max = $urandom_range(3, 1);
      hold_min = 1;
      hold_max = $urandom_range(3, 1);
      run_cmd(6'($urandom), $urandom, 7'($urandom), ($urandom_range(3, 0) == 0) ? 10 : -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
